// File: rtl/debug_overlay_renderer_if.sv
`default_nettype none
// ============================================================================
//  Module   : debug_overlay_renderer_if
//  Purpose  : Pixel-position, register-snapshot and colour signals shared by
//             the debug overlay renderer and whatever drives/consumes it.
//  Revision : 1.0 - initial release
// ============================================================================
interface debug_overlay_renderer_if #(
    parameter int REG_COUNT  = 16,
    parameter int DATA_WIDTH = 16
);
    logic [10:0]                      x;
    logic [10:0]                      y;
    logic                             frameStart;
    logic [REG_COUNT*DATA_WIDTH-1:0]  registerValue;
    logic                             pageNext;
    logic                             freeze;
    logic [2:0]                       r;
    logic [2:0]                       g;
    logic [2:0]                       b;
    logic [3:0]                       page;

    modport master (
        output x, y, frameStart, registerValue, pageNext, freeze,
        input  r, g, b, page
    );

    modport slave (
        input  x, y, frameStart, registerValue, pageNext, freeze,
        output r, g, b, page
    );
endinterface
`default_nettype wire

// File: rtl/debug_overlay_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : debug_overlay_renderer
//  Purpose  : Draws a paged hex dump of a register bank as an 8x16-character
//             panel over live video, highlighting values that changed since
//             the previous captured frame. Two-stage pixel pipeline.
//  Revision : 1.0 - initial release
// ============================================================================
module debug_overlay_renderer #(
    parameter int REG_COUNT  = 16,
    parameter int DATA_WIDTH = 16,
    parameter int PAGE_ROWS  = 8,
    parameter int ORIGIN_X   = 200,
    parameter int ORIGIN_Y   = 240
) (
    input  logic                      clk,
    input  logic                      rst,
    debug_overlay_renderer_if.slave   bus
);
    localparam int         c_NIBBLES   = DATA_WIDTH / 4;
    localparam int         c_NUM_PAGES = (REG_COUNT + PAGE_ROWS - 1) / PAGE_ROWS;
    localparam logic [3:0] c_LAST_PAGE = 4'(c_NUM_PAGES - 1);
    localparam int         c_PANEL_W   = 8 * (2 + c_NIBBLES);
    localparam int         c_PANEL_H   = 16 * PAGE_ROWS;

    // Seven-segment style hex glyphs in an 8x16 cell: segments live on
    // rows 1/7/14 and columns 1/6, leaving a one-pixel gutter around each.
    function automatic logic glyph_px(input logic [3:0] nib,
                                      input logic [3:0] row,
                                      input logic [2:0] col);
        logic [6:0] s;
        logic       top, mid, bot, upper, lower, hspan, left, right;
        case (nib)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
        endcase
        top   = (row == 4'd1);
        mid   = (row == 4'd7);
        bot   = (row == 4'd14);
        upper = (row >= 4'd1) && (row <= 4'd7);
        lower = (row >= 4'd7) && (row <= 4'd14);
        hspan = (col >= 3'd1) && (col <= 3'd6);
        left  = (col == 3'd1);
        right = (col == 3'd6);
        return (s[0] && top && hspan)   || (s[1] && right && upper) ||
               (s[2] && right && lower) || (s[3] && bot && hspan)   ||
               (s[4] && left && lower)  || (s[5] && left && upper)  ||
               (s[6] && mid && hspan);
    endfunction

    logic [DATA_WIDTH-1:0] r_snap [REG_COUNT];
    logic [REG_COUNT-1:0]  r_changed;
    logic                  r_shown;     // panel stays blank until the first frameStart after reset
    logic [3:0]            r_page;
    logic                  r_pending;

    logic                  r_s1_en;
    logic [3:0]            r_s1_nib;
    logic [3:0]            r_s1_grow;
    logic [2:0]            r_s1_gcol;
    logic                  r_s1_chg;

    logic [2:0]            r_r, r_g, r_b;

    logic [10:0]           w_dx, w_dy;
    logic [7:0]            w_col;
    logic [6:0]            w_row;
    logic [7:0]            w_reg_idx;
    logic                  w_in_panel, w_on_screen, w_reg_ok;
    logic [DATA_WIDTH-1:0] w_val;
    logic                  w_chg, w_glyph, w_s1_en, w_lit;
    logic [3:0]            w_nib;

    // Snapshot capture and page stepping, both only at frame start.
    // A pageNext arriving on the frameStart cycle belongs to the new frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < REG_COUNT; k++) r_snap[k] <= '0;
            r_changed <= '0;
            r_shown   <= 1'b0;
            r_page    <= 4'd0;
            r_pending <= 1'b0;
        end else if (bus.frameStart) begin
            r_shown <= 1'b1;
            if (!bus.freeze) begin
                for (int k = 0; k < REG_COUNT; k++) begin
                    r_snap[k]    <= bus.registerValue[k*DATA_WIDTH +: DATA_WIDTH];
                    r_changed[k] <= (bus.registerValue[k*DATA_WIDTH +: DATA_WIDTH] != r_snap[k]);
                end
            end
            if (r_pending) r_page <= (r_page == c_LAST_PAGE) ? 4'd0 : r_page + 4'd1;
            r_pending <= bus.pageNext;
        end else if (bus.pageNext) begin
            r_pending <= 1'b1;
        end
    end

    assign w_dx        = bus.x - 11'(ORIGIN_X);
    assign w_dy        = bus.y - 11'(ORIGIN_Y);
    assign w_col       = w_dx[10:3];
    assign w_row       = w_dy[10:4];
    assign w_in_panel  = (bus.x >= 11'(ORIGIN_X)) && (w_dx < 11'(c_PANEL_W)) &&
                         (bus.y >= 11'(ORIGIN_Y)) && (w_dy < 11'(c_PANEL_H));
    assign w_on_screen = (bus.x < 11'd640) && (bus.y < 11'd480);
    assign w_reg_idx   = 8'(32'(r_page) * PAGE_ROWS + 32'(w_row));
    assign w_reg_ok    = (w_reg_idx < 8'(REG_COUNT));

    // Character decode: column 0 is the register index, column 1 a gap,
    // the rest are value nibbles with the most significant one leftmost.
    always_comb begin
        w_val   = '0;
        w_chg   = 1'b0;
        w_glyph = 1'b0;
        w_nib   = w_reg_idx[3:0];
        for (int k = 0; k < REG_COUNT; k++) begin
            if (w_reg_idx == 8'(k)) begin
                w_val = r_snap[k];
                w_chg = r_changed[k];
            end
        end
        if (w_col == 8'd0) w_glyph = 1'b1;
        for (int n = 0; n < c_NIBBLES; n++) begin
            if (w_col == 8'(c_NIBBLES + 1 - n)) begin
                w_glyph = 1'b1;
                w_nib   = w_val[n*4 +: 4];
            end
        end
    end

    assign w_s1_en = w_in_panel && w_on_screen && w_reg_ok && w_glyph && r_shown;

    // Stage 1: register the character/glyph-cell decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_en   <= 1'b0;
            r_s1_nib  <= 4'd0;
            r_s1_grow <= 4'd0;
            r_s1_gcol <= 3'd0;
            r_s1_chg  <= 1'b0;
        end else begin
            r_s1_en   <= w_s1_en;
            r_s1_nib  <= w_nib;
            r_s1_grow <= w_dy[3:0];
            r_s1_gcol <= w_dx[2:0];
            r_s1_chg  <= w_chg;
        end
    end

    assign w_lit = r_s1_en && glyph_px(r_s1_nib, r_s1_grow, r_s1_gcol);

    // Stage 2: glyph lookup and colour; changed registers draw in yellow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_r <= 3'd0;
            r_g <= 3'd0;
            r_b <= 3'd0;
        end else begin
            r_r <= w_lit ? 3'd7 : 3'd0;
            r_g <= w_lit ? 3'd7 : 3'd0;
            r_b <= (w_lit && !r_s1_chg) ? 3'd7 : 3'd0;
        end
    end

    assign bus.r    = r_r;
    assign bus.g    = r_g;
    assign bus.b    = r_b;
    assign bus.page = r_page;
endmodule
`default_nettype wire

// File: doc/debug_overlay_renderer.md
DEBUG_OVERLAY_RENDERER -- requirements
Module: debug_overlay_renderer

Interface
REQ-001 Parameter REG_COUNT, default 16: number of registers displayed; legal range 1..16.
REQ-002 Parameter DATA_WIDTH, default 16: bits per register; multiple of 4, 4..32.
REQ-003 Parameter PAGE_ROWS, default 8: register rows shown per page; legal range 1..16.
REQ-004 Parameter ORIGIN_X, default 200: pixel x of the top-left corner of the panel.
REQ-005 Parameter ORIGIN_Y, default 240: pixel y of the top-left corner of the panel.
REQ-006 clk  input  1  pixel clock; the only clock.
REQ-007 rst  input  1  reset; asynchronous, active-low.
REQ-008 x  input  11  current pixel column.
REQ-009 y  input  11  current pixel row.
REQ-010 frameStart  input  1  one-cycle pulse at the start of vertical blank.
REQ-011 registerValue  input  REG_COUNT*DATA_WIDTH  live register values; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-012 pageNext  input  1  one-cycle request to advance the displayed page.
REQ-013 freeze  input  1  level; while high, the snapshot is not updated.
REQ-014 r, g, b  output  3 each  registered pixel colour.
REQ-015 page  output  4  currently displayed page index.

Function
REQ-016 NUM_PAGES SHALL equal ceil(REG_COUNT/PAGE_ROWS).
REQ-017 On a frameStart cycle with freeze low, the block SHALL copy registerValue into the snapshot; per register, changed[i] SHALL be set to (new value != previous snapshot value).
REQ-018 On a frameStart cycle with freeze high, the snapshot and changed[] SHALL hold.
REQ-019 pageNext SHALL set a pending flag; page SHALL change only on frameStart, whether or not freeze is high.
REQ-020 On frameStart with pending set, page SHALL become page+1, wrapping from NUM_PAGES-1 to 0, and pending SHALL clear.
REQ-021 pageNext coincident with frameStart SHALL remain pending and be applied at the next frameStart.
REQ-022 Additional pageNext pulses while pending is set SHALL be ignored; at most one page advance occurs per frame.
REQ-023 Panel geometry: row k (0..PAGE_ROWS-1) SHALL span y in [ORIGIN_Y+16k, ORIGIN_Y+16k+15].
REQ-024 Panel geometry: character column c SHALL span x in [ORIGIN_X+8c, ORIGIN_X+8c+7].
REQ-025 Row k SHALL display register index i = page*PAGE_ROWS+k.
REQ-026 Row content: column 0 SHALL hold hex digit i; column 1 SHALL be blank; columns 2..1+DATA_WIDTH/4 SHALL hold the snapshot value, most-significant nibble first.
REQ-027 Rows with i >= REG_COUNT, and all pixels outside the panel, SHALL be background.
REQ-028 Glyph pixels SHALL come from the codebase standard 8x16 hex font ROM, indexed by nibble, glyph row (y-cell top) and glyph column (x-cell left).
REQ-029 Colours: lit glyph pixel SHALL be 7/7/7 when changed[i]=0 and 7/7/0 when changed[i]=1.
REQ-030 Colours: background SHALL be 0/0/0.
REQ-031 Colours: any pixel with x>=640 or y>=480 SHALL be 0/0/0 regardless of content.
REQ-032 Pipeline: r/g/b SHALL be valid exactly 2 clk cycles after the x,y they correspond to.
REQ-033 Pipeline stage 1 SHALL register the row/column/nibble decode; stage 2 SHALL register the glyph lookup and colour.
REQ-034 A snapshot or page update SHALL be visible to pixels whose x,y arrive at or after the cycle following frameStart.

Reset
REQ-035 While rst is low, all of the following SHALL be zero: snapshot, changed[], page, pending, both pipeline stages, and r/g/b.
REQ-036 Deassertion of rst SHALL take effect at the next clk edge; a frameStart on that edge SHALL be honoured.
REQ-037 Reset asserted mid-frame SHALL force r/g/b to 0 asynchronously, with no wait for a clk edge.

Verification
REQ-038 Defaults; registerValue reg3=16'h1234; frameStart; freeze=0 -> row 3 (y 288..303) shows "3 1234" in 7/7/0; next frameStart with same value -> 7/7/7.
REQ-039 freeze=1; reg0 changed to 16'hFFFF; frameStart -> display still shows the old reg0 value, and changed[0] is unchanged.
REQ-040 pageNext three times in one frame, then frameStart -> page=1 and rows show regs 8..15; pageNext + frameStart on the same cycle -> page stays 1 until the following frameStart, then wraps to 0.
REQ-041 REG_COUNT=10, PAGE_ROWS=8, page=1 -> rows 0..1 show regs 8..9; rows 2..7 are 0/0/0.
REQ-042 Drive x=ORIGIN_X+16 (first value column), y=ORIGIN_Y at cycle n -> r/g/b match the font ROM pixel at cycle n+2 and not before; x=700 -> 0/0/0.
REQ-043 Assert rst low mid-line -> r/g/b=0 immediately and page=0; after release, the panel stays background until the first frameStart.
